// File: rtl/instr_register_pkg.sv
// Shared types and default sizing for the instruction register stack and its ALU.
package instr_register_pkg;

   localparam int unsigned DEPTH_DEF     = 32;
   localparam int unsigned OP_WIDTH_DEF  = 32;
   localparam int unsigned RES_WIDTH_DEF = 2 * OP_WIDTH_DEF;

   typedef enum logic [3:0] {
      ZERO  = 4'd0,
      PASSA = 4'd1,
      PASSB = 4'd2,
      ADD   = 4'd3,
      SUB   = 4'd4,
      MULT  = 4'd5,
      DIV   = 4'd6,
      MOD   = 4'd7
   } opcode_t;

   typedef logic signed [OP_WIDTH_DEF-1:0]  operand_t;
   typedef logic signed [RES_WIDTH_DEF-1:0] result_t;

   typedef struct packed {
      opcode_t  opc;
      operand_t op_a;
      operand_t op_b;
      result_t  res;
   } instruction_t;

endpackage

// File: rtl/instr_register_alu_if.sv
// Write/read bus between the instruction source and the register stack.
interface instr_register_alu_if
   import instr_register_pkg::*;
#(
   parameter int unsigned DEPTH = DEPTH_DEF
) ();

   localparam int unsigned ADDR_W = $clog2(DEPTH);

   logic              load_en;
   logic              wp_auto;
   logic [ADDR_W-1:0] write_pointer;
   opcode_t           opcode;
   operand_t          operand_a;
   operand_t          operand_b;
   logic              rd_en;
   logic [ADDR_W-1:0] read_pointer;
   instruction_t      instruction_word;
   logic              rd_valid;
   logic              rd_err;
   logic              full;
   logic [ADDR_W:0]   wr_count;

   modport master (
      output load_en, wp_auto, write_pointer, opcode, operand_a, operand_b,
             rd_en, read_pointer,
      input  instruction_word, rd_valid, rd_err, full, wr_count
   );

   modport slave (
      input  load_en, wp_auto, write_pointer, opcode, operand_a, operand_b,
             rd_en, read_pointer,
      output instruction_word, rd_valid, rd_err, full, wr_count
   );

endinterface

// File: rtl/instr_alu.sv
// Combinational executor: full-precision signed result for one opcode/operand pair.
module instr_alu
   import instr_register_pkg::*;
#(
   parameter int unsigned OP_WIDTH = OP_WIDTH_DEF
) (
   input  opcode_t                     opcode_i,
   input  logic signed [OP_WIDTH-1:0]  op_a_i,
   input  logic signed [OP_WIDTH-1:0]  op_b_i,
   output logic signed [2*OP_WIDTH-1:0] res_c_o
);

   localparam int unsigned RES_W = 2 * OP_WIDTH;

   logic signed [RES_W-1:0] a_ext;
   logic signed [RES_W-1:0] b_ext;

   // Sign-extend first so no operation can overflow the result width.
   assign a_ext = RES_W'(op_a_i);
   assign b_ext = RES_W'(op_b_i);

   always_comb begin
      res_c_o = '0;
      case (opcode_i)
         ZERO:  res_c_o = '0;
         PASSA: res_c_o = a_ext;
         PASSB: res_c_o = b_ext;
         ADD:   res_c_o = a_ext + b_ext;
         SUB:   res_c_o = a_ext - b_ext;
         MULT:  res_c_o = a_ext * b_ext;
         DIV:   if (b_ext != '0) res_c_o = a_ext / b_ext;
         MOD:   if (b_ext != '0) res_c_o = a_ext % b_ext;
         default: res_c_o = '0;
      endcase
   end

endmodule

// File: rtl/instr_register_alu.sv
// Instruction register stack: execute-then-commit write pipeline, registered reads
// with never-written detection, and fill tracking.
module instr_register_alu
   import instr_register_pkg::*;
#(
   parameter int unsigned DEPTH    = DEPTH_DEF,
   parameter int unsigned OP_WIDTH = OP_WIDTH_DEF
) (
   input logic                 clk,
   input logic                 reset_n,
   instr_register_alu_if.slave bus
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W  = ADDR_W + 1;

   logic              s1_valid_q, s1_valid_d;
   logic [ADDR_W-1:0] s1_addr_q,  s1_addr_d;
   instruction_t      s1_instr_q, s1_instr_d;
   logic [ADDR_W-1:0] wp_cnt_q,   wp_cnt_d;
   result_t           alu_res_c;

   instruction_t      mem_q [DEPTH];
   logic [DEPTH-1:0]  vld_q;

   logic [CNT_W-1:0]  wr_count_q, wr_count_d;
   logic              full_q,     full_d;

   instruction_t      rd_word_q,  rd_word_d;
   logic              rd_valid_q, rd_valid_d;
   logic              rd_err_q,   rd_err_d;

   logic              new_entry_c;
   logic              rd_hit_c;

   instr_alu #(
      .OP_WIDTH (OP_WIDTH)
   ) u_alu (
      .opcode_i (bus.opcode),
      .op_a_i   (bus.operand_a),
      .op_b_i   (bus.operand_b),
      .res_c_o  (alu_res_c)
   );

   // Next-state for execute stage, fill counter and read port.
   always_comb begin
      s1_valid_d = bus.load_en;
      s1_addr_d  = s1_addr_q;
      s1_instr_d = s1_instr_q;
      wp_cnt_d   = wp_cnt_q;
      wr_count_d = wr_count_q;
      rd_valid_d = bus.rd_en;
      rd_word_d  = rd_word_q;
      rd_err_d   = rd_err_q;

      if (bus.load_en) begin
         s1_addr_d  = bus.wp_auto ? wp_cnt_q : bus.write_pointer;
         s1_instr_d = '{opc:  bus.opcode,
                        op_a: bus.operand_a,
                        op_b: bus.operand_b,
                        res:  alu_res_c};
         if (bus.wp_auto) wp_cnt_d = wp_cnt_q + ADDR_W'(1);
      end

      new_entry_c = s1_valid_q && !vld_q[s1_addr_q];
      if (new_entry_c && (wr_count_q != CNT_W'(DEPTH))) begin
         wr_count_d = wr_count_q + CNT_W'(1);
      end
      full_d = (wr_count_d == CNT_W'(DEPTH));

      // A commit landing on the read address this edge wins over the stored copy.
      rd_hit_c = s1_valid_q && (s1_addr_q == bus.read_pointer);
      if (bus.rd_en) begin
         if (rd_hit_c) begin
            rd_word_d = s1_instr_q;
            rd_err_d  = 1'b0;
         end else if (vld_q[bus.read_pointer]) begin
            rd_word_d = mem_q[bus.read_pointer];
            rd_err_d  = 1'b0;
         end else begin
            rd_word_d = '0;
            rd_err_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_addr_q  <= '0;
         s1_instr_q <= '0;
         wp_cnt_q   <= '0;
         vld_q      <= '0;
         wr_count_q <= '0;
         full_q     <= 1'b0;
         rd_word_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[ADDR_W'(i)] <= '0;
         end
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_addr_q  <= s1_addr_d;
         s1_instr_q <= s1_instr_d;
         wp_cnt_q   <= wp_cnt_d;
         wr_count_q <= wr_count_d;
         full_q     <= full_d;
         rd_word_q  <= rd_word_d;
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
         if (s1_valid_q) begin
            mem_q[s1_addr_q] <= s1_instr_q;
            vld_q[s1_addr_q] <= 1'b1;
         end
      end
   end

   assign bus.instruction_word = rd_word_q;
   assign bus.rd_valid         = rd_valid_q;
   assign bus.rd_err           = rd_err_q;
   assign bus.full             = full_q;
   assign bus.wr_count         = wr_count_q;

endmodule

// File: tb/tb_instr_register_alu.sv
// Bench for instr_register_alu: directed scenarios plus random traffic against
// an array-based reference of the register stack.
module tb_instr_register_alu;
   import instr_register_pkg::*;

   localparam int DEPTH  = 32;
   localparam int ADDR_W = 5;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   instr_register_alu_if #(.DEPTH(DEPTH)) bus ();

   instr_register_alu #(
      .DEPTH    (DEPTH),
      .OP_WIDTH (OP_WIDTH_DEF)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;

   // Reference state: stored entries, written flags, fill count, auto pointer,
   // and the one write that has been accepted but not yet stored.
   instruction_t m_mem [DEPTH];
   bit           m_wr  [DEPTH];
   int           m_cnt  = 0;
   int           m_ptr  = 0;
   bit           p_v    = 1'b0;
   int           p_addr = 0;
   instruction_t p_e    = '0;
   instruction_t exp_word  = '0;
   bit           exp_valid = 1'b0;
   bit           exp_err   = 1'b0;

   function automatic result_t ref_res(opcode_t op, operand_t a, operand_t b);
      longint la = longint'(a);
      longint lb = longint'(b);
      longint r;
      case (op)
         PASSA:   r = la;
         PASSB:   r = lb;
         ADD:     r = la + lb;
         SUB:     r = la - lb;
         MULT:    r = la * lb;
         DIV:     r = (lb == 0) ? 64'sd0 : la / lb;
         MOD:     r = (lb == 0) ? 64'sd0 : la % lb;
         default: r = 0;
      endcase
      return result_t'(r);
   endfunction

   function automatic operand_t rand_operand();
      case ($urandom_range(0, 7))
         0:       return 32'sd0;
         1:       return 32'sh8000_0000;
         2:       return 32'sh7fff_ffff;
         3:       return operand_t'(int'($urandom_range(0, 20)) - 10);
         default: return operand_t'($urandom);
      endcase
   endfunction

   // Advance one clock: update the reference from the inputs seen at this edge.
   task automatic tick();
      int rp;
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_wr[i]  = 1'b0;
         end
         m_cnt = 0; m_ptr = 0; p_v = 1'b0;
         exp_word = '0; exp_valid = 1'b0; exp_err = 1'b0;
      end else begin
         rp = int'(bus.read_pointer);
         exp_valid = bus.rd_en;
         if (bus.rd_en) begin
            if (p_v && p_addr == rp) begin
               exp_word = p_e;       exp_err = 1'b0;
            end else if (m_wr[rp]) begin
               exp_word = m_mem[rp]; exp_err = 1'b0;
            end else begin
               exp_word = '0;        exp_err = 1'b1;
            end
         end
         if (p_v) begin
            if (!m_wr[p_addr]) begin
               m_wr[p_addr] = 1'b1;
               m_cnt++;
            end
            m_mem[p_addr] = p_e;
         end
         p_v = bus.load_en;
         if (bus.load_en) begin
            p_addr = bus.wp_auto ? m_ptr : int'(bus.write_pointer);
            if (bus.wp_auto) m_ptr = (m_ptr + 1) % DEPTH;
            p_e = '{opc: bus.opcode, op_a: bus.operand_a, op_b: bus.operand_b,
                    res: ref_res(bus.opcode, bus.operand_a, bus.operand_b)};
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.load_en       = 1'b0;
      bus.wp_auto       = 1'b0;
      bus.write_pointer = '0;
      bus.opcode        = ZERO;
      bus.operand_a     = '0;
      bus.operand_b     = '0;
      bus.rd_en         = 1'b0;
      bus.read_pointer  = '0;
   endtask

   task automatic set_write(input opcode_t op, input operand_t a, input operand_t b,
                            input logic auto_wp, input int addr);
      bus.load_en       = 1'b1;
      bus.wp_auto       = auto_wp;
      bus.write_pointer = ADDR_W'(addr);
      bus.opcode        = op;
      bus.operand_a     = a;
      bus.operand_b     = b;
   endtask

   task automatic set_read(input int addr);
      bus.rd_en        = 1'b1;
      bus.read_pointer = ADDR_W'(addr);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle();
      tick();
      tick();
      reset_n = 1'b1;
      checks++;
      if (bus.rd_valid !== 1'b0 || bus.rd_err !== 1'b0 || bus.instruction_word !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got valid=%b err=%b word=%h, want 0/0/0",
                  bus.rd_valid, bus.rd_err, bus.instruction_word);
      end
      checks++;
      if (bus.wr_count !== 6'd0 || bus.full !== 1'b0) begin
         failures++;
         $display("FAIL reset_count: got wr_count=%0d full=%b, want 0/0", bus.wr_count, bus.full);
      end
      for (int i = 0; i < DEPTH; i++) begin
         set_read(i);
         tick();
         checks++;
         if (bus.rd_valid !== 1'b1 || bus.rd_err !== 1'b1 || bus.instruction_word !== '0) begin
            failures++;
            $display("FAIL reset_read[%0d]: got valid=%b err=%b word=%h, want 1/1/0",
                     i, bus.rd_valid, bus.rd_err, bus.instruction_word);
         end
      end
      idle();
      tick();
      checks++;
      if (bus.rd_valid !== 1'b0 || bus.wr_count !== 6'd0 || bus.full !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: got valid=%b wr_count=%0d full=%b, want 0/0/0",
                  bus.rd_valid, bus.wr_count, bus.full);
      end
   endtask

   task automatic test_explicit_write();
      instruction_t e = '{opc: ADD, op_a: 32'sd7, op_b: -32'sd3, res: 64'sd4};
      set_write(ADD, 32'sd7, -32'sd3, 1'b0, 5);
      tick();
      idle();
      tick();
      checks++;
      if (bus.wr_count !== 6'd1) begin
         failures++;
         $display("FAIL explicit_count: got %0d want 1", bus.wr_count);
      end
      set_read(5);
      tick();
      idle();
      checks++;
      if (bus.instruction_word !== e || bus.rd_err !== 1'b0 || bus.rd_valid !== 1'b1) begin
         failures++;
         $display("FAIL explicit_read: got word=%h err=%b valid=%b want word=%h err=0 valid=1",
                  bus.instruction_word, bus.rd_err, bus.rd_valid, e);
      end
   endtask

   task automatic test_auto_wrap();
      reset_n = 1'b0;
      idle();
      tick();
      reset_n = 1'b1;
      for (int i = 0; i <= DEPTH; i++) begin
         set_write(PASSA, operand_t'(i), operand_t'($urandom), 1'b1, int'($urandom_range(0, 31)));
         tick();
         if (i == DEPTH - 1) begin
            checks++;
            if (bus.wr_count !== 6'd31 || bus.full !== 1'b0) begin
               failures++;
               $display("FAIL wrap_31: got wr_count=%0d full=%b want 31/0", bus.wr_count, bus.full);
            end
         end
      end
      checks++;
      if (bus.wr_count !== 6'd32 || bus.full !== 1'b1) begin
         failures++;
         $display("FAIL wrap_full: got wr_count=%0d full=%b want 32/1", bus.wr_count, bus.full);
      end
      idle();
      tick();
      checks++;
      if (bus.wr_count !== 6'd32 || bus.full !== 1'b1) begin
         failures++;
         $display("FAIL wrap_overwrite: got wr_count=%0d full=%b want 32/1", bus.wr_count, bus.full);
      end
      set_read(0);
      tick();
      checks++;
      if (bus.instruction_word.opc !== PASSA || bus.instruction_word.op_a !== 32'sd32 ||
          bus.instruction_word.res !== 64'sd32 || bus.rd_err !== 1'b0) begin
         failures++;
         $display("FAIL wrap_addr0: got opc=%0d a=%0d res=%0d err=%b want 1/32/32/0",
                  bus.instruction_word.opc, bus.instruction_word.op_a,
                  bus.instruction_word.res, bus.rd_err);
      end
      set_read(31);
      tick();
      idle();
      checks++;
      if (bus.instruction_word.op_a !== 32'sd31 || bus.instruction_word.res !== 64'sd31) begin
         failures++;
         $display("FAIL wrap_addr31: got a=%0d res=%0d want 31/31",
                  bus.instruction_word.op_a, bus.instruction_word.res);
      end
   endtask

   task automatic test_arith();
      opcode_t  top [8] = '{DIV, MOD, DIV, MULT, SUB, PASSB, ZERO, ADD};
      operand_t ta  [8] = '{-32'sd9, -32'sd9, 32'sd5, 32'sh8000_0000, 32'sh8000_0000,
                            32'sd11, 32'sd123, 32'sh7fff_ffff};
      operand_t tb  [8] = '{32'sd2, 32'sd2, 32'sd0, 32'sh8000_0000, 32'sd1,
                            -32'sd4, 32'sd5, 32'sh7fff_ffff};
      result_t  tr  [8] = '{-64'sd4, -64'sd1, 64'sd0, 64'sh4000_0000_0000_0000,
                            -64'sd2147483649, -64'sd4, 64'sd0, 64'sd4294967294};
      for (int k = 0; k < 8; k++) begin
         set_write(top[k], ta[k], tb[k], 1'b0, 8 + k);
         tick();
      end
      idle();
      tick();
      for (int k = 0; k < 8; k++) begin
         set_read(8 + k);
         tick();
         checks++;
         if (bus.instruction_word !== '{opc: top[k], op_a: ta[k], op_b: tb[k], res: tr[k]} ||
             bus.rd_err !== 1'b0) begin
            failures++;
            $display("FAIL arith[%0d]: got opc=%0d res=%0d err=%b want opc=%0d res=%0d err=0",
                     k, bus.instruction_word.opc, bus.instruction_word.res, bus.rd_err,
                     top[k], tr[k]);
         end
      end
      idle();
   endtask

   task automatic test_collision();
      set_write(MULT, 32'sd6, 32'sd7, 1'b0, 3);
      tick();
      idle();
      set_read(3);
      tick();
      idle();
      checks++;
      if (bus.instruction_word !== '{opc: MULT, op_a: 32'sd6, op_b: 32'sd7, res: 64'sd42} ||
          bus.rd_err !== 1'b0 || bus.rd_valid !== 1'b1) begin
         failures++;
         $display("FAIL collision: got opc=%0d res=%0d err=%b valid=%b want MULT/42/0/1",
                  bus.instruction_word.opc, bus.instruction_word.res, bus.rd_err, bus.rd_valid);
      end
      checks++;
      if (bus.wr_count !== 6'd32 || bus.full !== 1'b1) begin
         failures++;
         $display("FAIL collision_count: got wr_count=%0d full=%b want 32/1", bus.wr_count, bus.full);
      end
   endtask

   task automatic test_reset_inflight();
      set_write(SUB, 32'sd1, 32'sd1, 1'b0, 7);
      tick();
      reset_n = 1'b0;
      idle();
      tick();
      reset_n = 1'b1;
      tick();
      set_read(7);
      tick();
      idle();
      checks++;
      if (bus.rd_err !== 1'b1 || bus.instruction_word !== '0) begin
         failures++;
         $display("FAIL inflight_read: got err=%b word=%h want 1/0", bus.rd_err, bus.instruction_word);
      end
      tick();
      checks++;
      if (bus.wr_count !== 6'd0 || bus.full !== 1'b0) begin
         failures++;
         $display("FAIL inflight_count: got wr_count=%0d full=%b want 0/0", bus.wr_count, bus.full);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         reset_n           = ($urandom_range(0, 149) != 0);
         bus.load_en       = ($urandom_range(0, 3) != 0);
         bus.wp_auto       = $urandom_range(0, 1) == 1;
         bus.write_pointer = ADDR_W'($urandom);
         bus.opcode        = opcode_t'($urandom_range(0, 7));
         bus.operand_a     = rand_operand();
         bus.operand_b     = rand_operand();
         bus.rd_en         = $urandom_range(0, 1) == 1;
         bus.read_pointer  = ADDR_W'($urandom);
         tick();
         checks++;
         if (bus.rd_valid !== exp_valid || bus.rd_err !== exp_err ||
             bus.instruction_word !== exp_word) begin
            failures++;
            $display("FAIL random_read[%0d]: got v=%b e=%b w=%h want v=%b e=%b w=%h",
                     n, bus.rd_valid, bus.rd_err, bus.instruction_word,
                     exp_valid, exp_err, exp_word);
         end
         checks++;
         if (bus.wr_count !== 6'(m_cnt) || bus.full !== (m_cnt == DEPTH)) begin
            failures++;
            $display("FAIL random_count[%0d]: got wr_count=%0d full=%b want %0d/%b",
                     n, bus.wr_count, bus.full, m_cnt, (m_cnt == DEPTH));
         end
      end
      reset_n = 1'b1;
      idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      idle();
      test_reset();
      test_explicit_write();
      test_auto_wrap();
      test_arith();
      test_collision();
      test_reset_inflight();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_register_alu.md
Name: instr_register_alu

Overview:
Parametrised instruction register stack. Each entry stores an opcode, two signed operands and a computed result, so the block executes its instructions as well as storing them.
- Writes pass through a one-stage execute pipeline before commit.
- Reads are registered and flag entries that have never been written.
- Sits between the instruction source (test driver or fetch logic) and the result consumer/scoreboard.

Parameters:
DEPTH, 32, number of register entries (power of 2, >= 2)
OP_WIDTH, 32, width of each signed operand; result is 2*OP_WIDTH signed
ADDR_W, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
reset_n  input  1  reset, synchronous, active-low
load_en  input  1  write request this cycle
wp_auto  input  1  1 = use internal write counter; 0 = use write_pointer
write_pointer  input  ADDR_W  explicit write address (used when wp_auto=0)
opcode  input  opcode_t  operation to store and execute
operand_a  input  OP_WIDTH  signed operand A
operand_b  input  OP_WIDTH  signed operand B
rd_en  input  1  read request this cycle
read_pointer  input  ADDR_W  read address
instruction_word  output  instruction_t  {opc, op_a, op_b, res} of the entry read
rd_valid  output  1  instruction_word valid (one-cycle pulse)
rd_err  output  1  entry read was never written since reset
full  output  1  every entry written at least once since reset
wr_count  output  ADDR_W+1  number of distinct entries written since reset

Behaviour:
- Reset (reset_n=0 at clock edge):
  - all entries cleared to 0; per-entry valid bits cleared
  - internal write counter = 0; pipeline stage emptied, so any in-flight write is discarded
  - instruction_word=0, rd_valid=0, rd_err=0, full=0, wr_count=0
- Stage 1 (edge N, load_en=1):
  - capture opcode and operands
  - capture address: internal counter if wp_auto=1, else write_pointer
  - when wp_auto=1, the counter increments and wraps DEPTH-1 -> 0
- Stage 2 (edge N+1): commit {opc, op_a, op_b, res} to the captured address and set its valid bit. Write latency is 2 edges.
- Back-to-back writes every cycle are sustained with no stall.
- Result computation (full 2*OP_WIDTH signed arithmetic, no overflow):
  - ZERO -> 0; PASSA -> a; PASSB -> b
  - ADD -> a+b; SUB -> a-b; MULT -> a*b
  - DIV -> a/b; MOD -> a%b (signed, truncating)
  - DIV or MOD with b=0 -> res=0
- Read:
  - rd_en=1 at edge M -> instruction_word, rd_err, rd_valid=1 at edge M+1
  - rd_en=0 -> rd_valid=0; instruction_word holds its last value
- Read of an unwritten entry: instruction_word=0, rd_err=1.
- Read/commit collision on the same address at the same edge is write-first: the read returns the newly committed data with rd_err=0.
- Overwrite of an already-valid entry: data replaced; wr_count and full unchanged.
- wr_count: increments only when a commit sets a previously clear valid bit; saturates at DEPTH. full = (wr_count == DEPTH).
- Switching wp_auto mid-stream does not reset the internal counter; the counter advances only on auto writes.
- Reset asserted while a write is in stage 1: that write never commits.

Decomposition:
- Shared package instr_register_pkg holds:
  - opcode_t: 4-bit enum ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
  - operand_t, result_t
  - instruction_t struct {opc, op_a, op_b, res}
  - default DEPTH and OP_WIDTH constants
- One sub-module, instr_alu: combinational opcode/operand -> result, parametrised on OP_WIDTH, instantiated in stage 1.

Test Plan:
- Reset, then read all 32 addresses -> each read returns rd_valid=1, rd_err=1, instruction_word=0; wr_count=0, full=0.
- wp_auto=0: write ADD a=7 b=-3 to address 5, then read 5 on the edge after commit -> opc=ADD, op_a=7, op_b=-3, res=4, rd_err=0, wr_count=1.
- wp_auto=1: 33 consecutive writes with PASSA a=i (i=0..32) -> address 0 holds a=32 (wrap); full=1 after the 32nd commit; wr_count stays 32.
- DIV a=-9 b=2 -> res=-4; MOD a=-9 b=2 -> res=-1; DIV a=5 b=0 -> res=0; MULT a=-2^31 b=-2^31 -> res=2^62.
- Read address 3 on the same edge that MULT a=6 b=7 commits to address 3 -> next cycle res=42, rd_err=0.
- load_en=1 for SUB a=1 b=1 at edge N, reset_n=0 at edge N+1 -> entry stays unwritten (read gives rd_err=1); wr_count=0.
